// File: rtl/cosine_pkg.sv
// Shared defaults, sample type and quarter-wave cosine table generator.
package cosine_pkg;

  localparam int unsigned PHASE_W_DEF = 16;
  localparam int unsigned LUT_AW_DEF  = 6;
  localparam int unsigned OUT_W_DEF   = 8;
  localparam int unsigned DIV_W_DEF   = 16;

  typedef logic signed [OUT_W_DEF-1:0] sample_t;

  // LUT[k] = round((2^(ow-1)-1) * cos(pi/2 * (k+0.5)/2^aw)); Taylor series keeps it elaboration-safe.
  function automatic int lut_entry(input int unsigned k, input int unsigned aw,
                                   input int unsigned ow);
    real x;
    real term;
    real sum;
    real amp;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(1 << aw);
    sum  = 1.0;
    term = 1.0;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    amp = real'((1 << (ow - 1)) - 1);
    return $rtoi(amp * sum + 0.5);
  endfunction

endpackage

// File: rtl/cosine_qlut.sv
// Quarter-wave cosine ROM, magnitude only, one cycle read latency.
module cosine_qlut
  import cosine_pkg::*;
#(
  parameter int unsigned LUT_AW = LUT_AW_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic              CLK,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data
);

  localparam int unsigned N = 1 << LUT_AW;

  logic [OUT_W-2:0] rom [N];

  // Constant table contents; all entries are positive magnitudes.
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = (OUT_W-1)'(lut_entry(k, LUT_AW, OUT_W));
  end

  // Registered read port.
  always_ff @(posedge CLK) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/cosine_gen.sv
// DDS cosine generator: rate divider, phase accumulator, quarter-wave ROM, sign stage.
module cosine_gen
  import cosine_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned LUT_AW  = LUT_AW_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               restart,
  input  logic               enable,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [DIV_W-1:0]   rate_div,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic [PHASE_W-1:0] phase_out
);

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] acc_next_c;
  logic [DIV_W-1:0]   cnt;
  logic               strobe_c;
  logic               clear_c;
  logic [1:0]         quad_c;
  logic [LUT_AW-1:0]  idx_c;
  logic [LUT_AW-1:0]  addr_c;
  logic [OUT_W-2:0]   mag;
  logic               neg_q;
  logic               valid_q;

  // Restart is a synchronous clear of everything RST clears.
  assign clear_c    = RST || restart;
  // ">=" so that lowering rate_div below cnt strobes immediately instead of wrapping.
  assign strobe_c   = enable && !restart && (cnt >= rate_div);
  assign acc_next_c = acc + tuning_word;

  // Quadrant and truncated table index; odd quadrants read the table mirrored (N-1-i == ~i).
  assign quad_c = acc[PHASE_W-1 -: 2];
  assign idx_c  = acc[PHASE_W-3 -: LUT_AW];
  assign addr_c = quad_c[0] ? ~idx_c : idx_c;

  // Sample-rate divider and phase accumulator; phase_out mirrors acc.
  always_ff @(posedge CLK) begin
    if (clear_c) begin
      cnt       <= '0;
      acc       <= '0;
      phase_out <= '0;
    end else if (strobe_c) begin
      cnt       <= '0;
      acc       <= acc_next_c;
      phase_out <= acc_next_c;
    end else if (enable) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  cosine_qlut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_qlut (
    .CLK  (CLK),
    .addr (addr_c),
    .data (mag)
  );

  // Stage 1: sign flag registered alongside the ROM read; valid tracks the strobe.
  always_ff @(posedge CLK) begin
    if (clear_c) begin
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      valid_q <= strobe_c;
      neg_q   <= quad_c[1] ^ quad_c[0];
    end
  end

  // Stage 2: apply sign; output holds between samples.
  always_ff @(posedge CLK) begin
    if (clear_c) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= valid_q;
      if (valid_q) begin
        sample_out <= neg_q ? -{1'b0, mag} : {1'b0, mag};
      end
    end
  end

endmodule

// File: tb/tb_cosine_gen.sv
// Randomized and directed bench for cosine_gen against a cycle-level behavioural model.
module tb_cosine_gen;
  import cosine_pkg::*;

  localparam int unsigned PW = PHASE_W_DEF;
  localparam int unsigned AW = LUT_AW_DEF;
  localparam int unsigned OW = OUT_W_DEF;
  localparam int unsigned DW = DIV_W_DEF;
  localparam int unsigned N  = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          restart;
  logic          enable;
  logic [PW-1:0] tuning_word;
  logic [DW-1:0] rate_div;
  logic [OW-1:0] sample_out;
  logic          sample_valid;
  logic [PW-1:0] phase_out;

  cosine_gen dut (
    .CLK          (CLK),
    .RST          (RST),
    .restart      (restart),
    .enable       (enable),
    .tuning_word  (tuning_word),
    .rate_div     (rate_div),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .phase_out    (phase_out)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: divider count, phase, pending samples keyed by the cycle they appear.
  typedef struct {
    longint due;
    int     val;
  } pend_t;

  int unsigned m_cnt = 0;
  int unsigned m_acc = 0;
  int          m_out = 0;
  int          m_valid = 0;
  longint      cyc = 0;
  pend_t       pend[$];
  int          seen[$];
  longint      seen_cyc[$];

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Ideal quadrant-mapped cosine sample for a phase value.
  function automatic int ref_cos(input int unsigned ph);
    int unsigned q;
    int unsigned i;
    int          mag;
    q   = ph / (1 << (PW - 2));
    i   = (ph % (1 << (PW - 2))) / (1 << (PW - 2 - AW));
    mag = (q % 2 == 1) ? lut_entry(N - 1 - i, AW, OW) : lut_entry(i, AW, OW);
    return (q == 1 || q == 2) ? -mag : mag;
  endfunction

  function automatic int seen_at(input int idx);
    if (idx < seen.size()) return seen[idx];
    return 9999;
  endfunction

  function automatic longint seen_cyc_at(input int idx);
    if (idx < seen_cyc.size()) return seen_cyc[idx];
    return -1;
  endfunction

  // One clock: check what the DUT shows now, drive next inputs, advance the model.
  task automatic step(input bit rst, input bit rs, input bit en, input int unsigned tw,
                      input int unsigned rd);
    @(negedge CLK);
    check("sample_valid", sample_valid, m_valid);
    check("sample_out", $signed(sample_out), m_out);
    check("phase_out", phase_out, m_acc);
    if (sample_valid === 1'b1) begin
      seen.push_back(int'($signed(sample_out)));
      seen_cyc.push_back(cyc);
    end
    RST         = rst;
    restart     = rs;
    enable      = en;
    tuning_word = PW'(tw);
    rate_div    = DW'(rd);
    if (rst || rs) begin
      m_cnt   = 0;
      m_acc   = 0;
      m_out   = 0;
      m_valid = 0;
      pend.delete();
    end else begin
      m_valid = 0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        m_out   = pend[0].val;
        m_valid = 1;
        void'(pend.pop_front());
      end
      if (en && m_cnt >= rd) begin
        pend.push_back('{cyc + 2, ref_cos(m_acc)});
        m_acc = (m_acc + tw) % (1 << PW);
        m_cnt = 0;
      end else if (en) begin
        m_cnt++;
      end
    end
    cyc++;
  endtask

  int     s;
  longint e;

  initial begin
    RST = 1'b1; restart = 1'b0; enable = 1'b1; tuning_word = PW'(256); rate_div = '0;
    @(posedge CLK);

    // Reset held with enable active.
    for (int k = 0; k < 4; k++) step(1, 0, 1, 256, 0);

    // Quarter-turn steps at full rate.
    s = seen.size();
    for (int k = 0; k < 12; k++) step(0, 0, 1, 16384, 0);
    check("q_seq0", seen_at(s), 127);
    check("q_seq1", seen_at(s + 1), -2);
    check("q_seq2", seen_at(s + 2), -127);
    check("q_seq3", seen_at(s + 3), 2);
    check("q_seq4", seen_at(s + 4), 127);

    // Half-turn steps with rate_div=3.
    step(0, 1, 1, 32768, 3);
    s = seen.size();
    for (int k = 0; k < 20; k++) step(0, 0, 1, 32768, 3);
    check("half_seq0", seen_at(s), 127);
    check("half_seq1", seen_at(s + 1), -127);
    check("half_seq2", seen_at(s + 2), 127);
    check("half_period", seen_cyc_at(s + 1) - seen_cyc_at(s), 4);

    // Full sweep through every table index.
    step(0, 1, 1, 256, 0);
    s = seen.size();
    for (int k = 0; k < 262; k++) step(0, 0, 1, 256, 0);
    check("sweep_n0", seen_at(s), 127);
    check("sweep_n128", seen_at(s + 128), -127);
    check("sweep_n256", seen_at(s + 256), 127);

    // Restart with samples in flight.
    for (int k = 0; k < 6; k++) step(0, 0, 1, 4096, 0);
    step(0, 1, 1, 4096, 0);
    s = seen.size();
    step(0, 0, 1, 4096, 0);
    check("restart_out0", $signed(sample_out), 0);
    check("restart_nvalid", sample_valid, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 4096, 0);
    check("restart_first", seen_at(s), 127);
    check("restart_first_cyc", seen_cyc_at(s) - (cyc - 7), 2);

    // Enable gap, then rate_div lowered below the held count.
    step(0, 1, 1, 4096, 9);
    for (int k = 0; k < 20 && m_cnt != 7; k++) step(0, 0, 1, 4096, 9);
    check("cnt_reached", m_cnt, 7);
    s = seen.size();
    for (int k = 0; k < 10; k++) step(0, 0, 0, 4096, 9);
    check("disabled_no_valid", seen.size() - s, 0);
    e = cyc;
    s = seen.size();
    for (int k = 0; k < 12; k++) step(0, 0, 1, 4096, 2);
    check("reenable_first", seen_cyc_at(s) - e, 2);
    check("reenable_period", seen_cyc_at(s + 1) - seen_cyc_at(s), 3);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 8, $urandom_range(0, 65535), $urandom_range(0, 4));
    end
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
